kinase_valve_sequencer: RTL
===========================

// Module: kinase_valve_sequencer
// PURPOSE
//  Programmable step sequencer for the 7-lane kinase activity chip.
//  - Drives the chip's control-layer pads: 13 valve lines (ctrl_a), 4 select
//    valves (ctrl_s), the 3-phase peristaltic pump (pump_a) and the 2-phase
//    pump (pump_b).
//  - Host writes a step table; on start the block plays it step by step.
//  - Each step holds its valve pattern, lets valves settle, then runs the
//    enabled pumps for the step's dwell.
// PARAMETERS
//  NUM_STEPS   16  step-table depth; must be a power of 2
//  DWELL_W     16  width of the per-step dwell count, in clk cycles
//  DIV_W       12  width of the pump phase-rate divider
//  SETTLE_CYC  8   cycles, after each valve change, with pumps forced to 0
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous, active-high reset
//  prog_we    in   1       step-table write strobe; ignored while busy=1
//  prog_addr  in   log2(NUM_STEPS)  step-table write address
//  prog_data  in   37      step word; field layout below
//  start      in   1       single-cycle pulse; begins a run at step 0
//  abort      in   1       single-cycle pulse; stops the run immediately
//  pump_div   in   DIV_W   pump phase advances every pump_div+1 cycles
//  busy       out  1       high from the cycle after start until the run ends
//  done       out  1       one-cycle pulse when a run completes normally
//  step_idx   out  log2(NUM_STEPS)  index of the step currently playing
//  ctrl_a     out  13      valve lines, 1 = pressurised (valve closed)
//  ctrl_s     out  4       select valve lines
//  pump_a     out  3       peristaltic pump A phase lines
//  pump_b     out  2       pump B phase lines
// BEHAVIOUR
//  Step word layout:
//    [36] last | [35:20] dwell | [19] pb_en | [18] pa_rev | [17] pa_en
//    | [16:13] ctrl_s | [12:0] ctrl_a
//  Reset, abort and IDLE state:
//    - All outputs are 0; state goes to IDLE. Step-table contents survive.
//    - Abort takes priority over every other event, including a same-cycle start.
//  FSM states: IDLE, LOAD, SETTLE, RUN, DONE.
//    - IDLE: on start, step_idx<=0, go to LOAD, busy<=1.
//      start is ignored in every state other than IDLE.
//    - LOAD (1 cycle): latch the table entry at step_idx into the output
//      registers; pumps=0; set settle_cnt=SETTLE_CYC-1. Go to SETTLE.
//    - SETTLE: valves held, pumps=0. When settle_cnt reaches 0: load
//      dwell_cnt (dwell 0 is treated as 1), reset the pump phase, go to RUN.
//    - RUN: valves held, enabled pumps sequence. dwell_cnt decrements each
//      cycle. Leave RUN after exactly max(dwell,1) RUN cycles:
//        - last=1 or step_idx==NUM_STEPS-1: go to DONE.
//          step_idx never wraps past the end of the table.
//        - otherwise: step_idx+1, go to LOAD.
//    - DONE (1 cycle): done=1, busy<=0, all outputs <=0, go to IDLE.
//  Latency: the ctrl_a/ctrl_s outputs for step 0 appear 2 cycles after the
//    start cycle. Pumps start SETTLE_CYC cycles after that.
//  Pump A (pa_en=1):
//    - Forward cycles through 6 phases: 001,011,010,110,100,101, then wraps.
//    - pa_rev=1 plays the same 6 phases in reverse order.
//    - Each RUN entry starts at phase 001.
//  Pump B (pb_en=1): alternates 01,10, starting at 01.
//  Phase timing: the phase counter advances when div_cnt==pump_div, and
//    div_cnt then clears to 0. pump_div=0 advances the phase every cycle.
//  A disabled pump outputs 0.
//  Writes: a prog_we in the same cycle as start is accepted, and the start
//    is still honoured.
//  pump_div is sampled every cycle; changing it mid-run takes effect on the
//    next div_cnt compare.
// STRUCTURE
//  Package kinase_ctrl_pkg holds:
//    - step word field offsets and widths, STEP_W=37;
//    - FSM state enum;
//    - pump A phase ROM constant (6 x 3 bits).
//  Sub-module kinase_pump_phase_gen holds the divider, phase counter and
//    direction logic. It is instanced twice (3-phase and 2-phase).
//  The step table is a NUM_STEPS x STEP_W register array with a sync write
//    port and a read at step_idx.
// TESTING
//  - Reset mid-RUN: all outputs go to 0, busy=0, state IDLE; the table is
//    unchanged and a second start replays the same steps.
//  - Single step (ctrl_a=13'h1A5, ctrl_s=4'h3, dwell=5, last=1, pumps off)
//    with SETTLE_CYC=8:
//      - ctrl_a=1A5 at start+2;
//      - outputs held for 8+5 cycles;
//      - done pulses 1 cycle; outputs then return to 0.
//  - Pump A forward, pump_div=1, dwell=12: pump_a shows 001,001,011,011,
//    010,010,... Repeat with pa_rev=1: pump_a shows 001,101,100,... (each
//    phase held 2 cycles).
//  - 3-step program (last bit only on step 2): step_idx goes 0,1,2; each
//    change has pumps=0 for 8 cycles; done is seen exactly once.
//  - No last bit set in any of the 16 steps: the run ends after step 15
//    with no wrap to step 0. Dwell=0 steps last exactly 1 RUN cycle.
//  - Abort and start in the same cycle during RUN: go to IDLE, outputs 0,
//    no done. prog_we while busy leaves the table entry unchanged.

Source files
------------

// File: rtl/kinase_ctrl_pkg.sv
// kinase_ctrl_pkg
//   Shared definitions for the kinase chip valve sequencer:
//   - step-word field offsets/widths and a packed view of the step word
//   - sequencer FSM state encoding
//   - phase pattern ROMs for the 3-phase pump A and the 2-phase pump B
//   - a helper that maps a programmed dwell of 0 onto 1 cycle
package kinase_ctrl_pkg;

  localparam int STEP_W     = 37;
  localparam int CTRL_A_LSB = 0;
  localparam int CTRL_A_W   = 13;
  localparam int CTRL_S_LSB = 13;
  localparam int CTRL_S_W   = 4;
  localparam int PA_EN_BIT  = 17;
  localparam int PA_REV_BIT = 18;
  localparam int PB_EN_BIT  = 19;
  localparam int DWELL_LSB  = 20;
  localparam int DWELL_FW   = 16;
  localparam int LAST_BIT   = 36;

  // Packed view of one step-table entry; MSB first, matching the offsets above
  typedef struct packed {
    logic                last;
    logic [DWELL_FW-1:0] dwell;
    logic                pb_en;
    logic                pa_rev;
    logic                pa_en;
    logic [CTRL_S_W-1:0] ctrl_s;
    logic [CTRL_A_W-1:0] ctrl_a;
  } step_word_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  localparam int PA_PHASES = 6;
  localparam int PA_W      = 3;
  localparam int PB_PHASES = 2;
  localparam int PB_W      = 2;

  // Entry 0 sits in the least significant slice: 001,011,010,110,100,101
  localparam logic [PA_PHASES*PA_W-1:0] PA_PHASE_ROM =
    {3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  // Pump B simply alternates 01,10
  localparam logic [PB_PHASES*PB_W-1:0] PB_PHASE_ROM = {2'b10, 2'b01};

  // A dwell of 0 still runs the pumps for one cycle
  function automatic logic [DWELL_FW-1:0] eff_dwell(input logic [DWELL_FW-1:0] dwell);
    return (dwell == {DWELL_FW{1'b0}}) ? {{(DWELL_FW-1){1'b0}}, 1'b1} : dwell;
  endfunction

endpackage

// File: rtl/kinase_pump_phase_gen.sv
// kinase_pump_phase_gen
//   Rate divider plus phase sequencer for one peristaltic pump.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     start        restart at phase 0 with the divider cleared (RUN entry)
//     run          advance through the phases at the divided rate
//     enable       pump enabled for this step; disabled pump drives 0
//     reverse      walk the phase table backwards
//     pump_div     phase advances every pump_div+1 cycles
//     phase_lines  registered pump phase outputs
//   With neither start nor run asserted the pump lines are forced to 0.
module kinase_pump_phase_gen #(
  parameter int                              NUM_PHASES = 6,
  parameter int                              PHASE_W    = 3,
  parameter int                              DIV_W      = 12,
  parameter logic [NUM_PHASES*PHASE_W-1:0]   PHASE_ROM  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               run,
  input  logic               enable,
  input  logic               reverse,
  input  logic [DIV_W-1:0]   pump_div,
  output logic [PHASE_W-1:0] phase_lines
);

  localparam int               IDX_W    = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]   phase_idx_q, phase_idx_d, phase_next;
  logic [PHASE_W-1:0] lines_q, lines_d;

  function automatic logic [PHASE_W-1:0] rom_entry(input logic [IDX_W-1:0] idx);
    return PHASE_ROM[int'(idx) * PHASE_W +: PHASE_W];
  endfunction

  // Neighbouring phase index in the selected direction, wrapping at both ends
  always_comb begin
    phase_next = phase_idx_q;
    if (reverse) begin
      if (phase_idx_q == {IDX_W{1'b0}}) begin
        phase_next = LAST_IDX;
      end else begin
        phase_next = phase_idx_q - IDX_W'(1);
      end
    end else begin
      if (phase_idx_q == LAST_IDX) begin
        phase_next = {IDX_W{1'b0}};
      end else begin
        phase_next = phase_idx_q + IDX_W'(1);
      end
    end
  end

  // Divider, phase index and output pattern next-state
  always_comb begin
    div_cnt_d   = div_cnt_q;
    phase_idx_d = phase_idx_q;
    lines_d     = lines_q;
    if (start) begin
      div_cnt_d   = {DIV_W{1'b0}};
      phase_idx_d = {IDX_W{1'b0}};
      lines_d     = enable ? rom_entry({IDX_W{1'b0}}) : {PHASE_W{1'b0}};
    end else if (run) begin
      if (div_cnt_q == pump_div) begin
        div_cnt_d   = {DIV_W{1'b0}};
        phase_idx_d = phase_next;
        lines_d     = enable ? rom_entry(phase_next) : {PHASE_W{1'b0}};
      end else begin
        div_cnt_d   = div_cnt_q + DIV_W'(1);
      end
    end else begin
      div_cnt_d   = {DIV_W{1'b0}};
      phase_idx_d = {IDX_W{1'b0}};
      lines_d     = {PHASE_W{1'b0}};
    end
  end

  // Pump generator state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= {DIV_W{1'b0}};
      phase_idx_q <= {IDX_W{1'b0}};
      lines_q     <= {PHASE_W{1'b0}};
    end else begin
      div_cnt_q   <= div_cnt_d;
      phase_idx_q <= phase_idx_d;
      lines_q     <= lines_d;
    end
  end

  assign phase_lines = lines_q;

endmodule

// File: rtl/kinase_valve_sequencer.sv
// kinase_valve_sequencer
//   Plays a host-written step table onto the kinase chip control layer.
//   Each step: LOAD valve pattern, SETTLE with pumps off, RUN pumps for dwell.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     prog_we/addr/data     step-table write port (ignored while busy)
//     start, abort          run control pulses (abort wins over everything)
//     pump_div              pump phase rate divider
//     busy, done, step_idx  run status
//     ctrl_a, ctrl_s        valve lines
//     pump_a, pump_b        pump phase lines
//   All outputs are registered. The step table has no reset so its contents
//   survive reset and abort.
module kinase_valve_sequencer
  import kinase_ctrl_pkg::*;
#(
  parameter int NUM_STEPS  = 16,
  parameter int DWELL_W    = 16,
  parameter int DIV_W      = 12,
  parameter int SETTLE_CYC = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         prog_we,
  input  logic [$clog2(NUM_STEPS)-1:0] prog_addr,
  input  logic [STEP_W-1:0]            prog_data,
  input  logic                         start,
  input  logic                         abort,
  input  logic [DIV_W-1:0]             pump_div,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic [CTRL_A_W-1:0]          ctrl_a,
  output logic [CTRL_S_W-1:0]          ctrl_s,
  output logic [PA_W-1:0]              pump_a,
  output logic [PB_W-1:0]              pump_b
);

  localparam int                  IDX_W       = $clog2(NUM_STEPS);
  localparam int                  SETTLE_W    = $clog2(SETTLE_CYC) + 1;
  localparam logic [IDX_W-1:0]    LAST_STEP   = IDX_W'(NUM_STEPS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYC - 1);

  step_word_t          step_table_q [NUM_STEPS];
  step_word_t          rd_word;

  seq_state_e          state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [IDX_W-1:0]    step_idx_q, step_idx_d;
  logic [CTRL_A_W-1:0] ctrl_a_q, ctrl_a_d;
  logic [CTRL_S_W-1:0] ctrl_s_q, ctrl_s_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_FW-1:0] cur_dwell_q, cur_dwell_d;
  logic                cur_last_q, cur_last_d;
  logic                cur_pa_en_q, cur_pa_en_d;
  logic                cur_pa_rev_q, cur_pa_rev_d;
  logic                cur_pb_en_q, cur_pb_en_d;
  logic                pump_start, pump_run;

  assign rd_word = step_table_q[step_idx_q];

  // Step-table write port; locked out for the whole run
  always_ff @(posedge clk) begin
    if (prog_we && !busy_q) begin
      step_table_q[prog_addr] <= step_word_t'(prog_data);
    end
  end

  // Sequencer next-state: abort overrides every state and any same-cycle start
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    step_idx_d   = step_idx_q;
    ctrl_a_d     = ctrl_a_q;
    ctrl_s_d     = ctrl_s_q;
    settle_cnt_d = settle_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    cur_dwell_d  = cur_dwell_q;
    cur_last_d   = cur_last_q;
    cur_pa_en_d  = cur_pa_en_q;
    cur_pa_rev_d = cur_pa_rev_q;
    cur_pb_en_d  = cur_pb_en_q;
    pump_start   = 1'b0;
    pump_run     = 1'b0;
    if (abort) begin
      state_d      = ST_IDLE;
      busy_d       = 1'b0;
      step_idx_d   = {IDX_W{1'b0}};
      ctrl_a_d     = {CTRL_A_W{1'b0}};
      ctrl_s_d     = {CTRL_S_W{1'b0}};
      settle_cnt_d = {SETTLE_W{1'b0}};
      dwell_cnt_d  = {DWELL_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_LOAD;
            busy_d     = 1'b1;
            step_idx_d = {IDX_W{1'b0}};
          end else begin
            state_d    = ST_IDLE;
          end
        end
        ST_LOAD: begin
          ctrl_a_d     = rd_word.ctrl_a;
          ctrl_s_d     = rd_word.ctrl_s;
          cur_dwell_d  = rd_word.dwell;
          cur_last_d   = rd_word.last;
          cur_pa_en_d  = rd_word.pa_en;
          cur_pa_rev_d = rd_word.pa_rev;
          cur_pb_en_d  = rd_word.pb_en;
          settle_cnt_d = SETTLE_INIT;
          state_d      = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == {SETTLE_W{1'b0}}) begin
            dwell_cnt_d = DWELL_W'(eff_dwell(cur_dwell_q));
            pump_start  = 1'b1;
            state_d     = ST_RUN;
          end else begin
            settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
          end
        end
        ST_RUN: begin
          // dwell_cnt holds the RUN cycles still to go, including this one
          if (dwell_cnt_q == DWELL_W'(1)) begin
            dwell_cnt_d = {DWELL_W{1'b0}};
            if (cur_last_q || (step_idx_q == LAST_STEP)) begin
              state_d    = ST_DONE;
              done_d     = 1'b1;
              step_idx_d = {IDX_W{1'b0}};
              ctrl_a_d   = {CTRL_A_W{1'b0}};
              ctrl_s_d   = {CTRL_S_W{1'b0}};
            end else begin
              step_idx_d = step_idx_q + IDX_W'(1);
              state_d    = ST_LOAD;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
            pump_run    = 1'b1;
          end
        end
        ST_DONE: begin
          busy_d     = 1'b0;
          step_idx_d = {IDX_W{1'b0}};
          state_d    = ST_IDLE;
        end
        default: begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          step_idx_d = {IDX_W{1'b0}};
          ctrl_a_d   = {CTRL_A_W{1'b0}};
          ctrl_s_d   = {CTRL_S_W{1'b0}};
        end
      endcase
    end
  end

  // Sequencer state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      step_idx_q   <= {IDX_W{1'b0}};
      ctrl_a_q     <= {CTRL_A_W{1'b0}};
      ctrl_s_q     <= {CTRL_S_W{1'b0}};
      settle_cnt_q <= {SETTLE_W{1'b0}};
      dwell_cnt_q  <= {DWELL_W{1'b0}};
      cur_dwell_q  <= {DWELL_FW{1'b0}};
      cur_last_q   <= 1'b0;
      cur_pa_en_q  <= 1'b0;
      cur_pa_rev_q <= 1'b0;
      cur_pb_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      step_idx_q   <= step_idx_d;
      ctrl_a_q     <= ctrl_a_d;
      ctrl_s_q     <= ctrl_s_d;
      settle_cnt_q <= settle_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      cur_dwell_q  <= cur_dwell_d;
      cur_last_q   <= cur_last_d;
      cur_pa_en_q  <= cur_pa_en_d;
      cur_pa_rev_q <= cur_pa_rev_d;
      cur_pb_en_q  <= cur_pb_en_d;
    end
  end

  kinase_pump_phase_gen #(
    .NUM_PHASES (PA_PHASES),
    .PHASE_W    (PA_W),
    .DIV_W      (DIV_W),
    .PHASE_ROM  (PA_PHASE_ROM)
  ) u_pump_a (
    .clk         (clk),
    .rst         (rst),
    .start       (pump_start),
    .run         (pump_run),
    .enable      (cur_pa_en_q),
    .reverse     (cur_pa_rev_q),
    .pump_div    (pump_div),
    .phase_lines (pump_a)
  );

  kinase_pump_phase_gen #(
    .NUM_PHASES (PB_PHASES),
    .PHASE_W    (PB_W),
    .DIV_W      (DIV_W),
    .PHASE_ROM  (PB_PHASE_ROM)
  ) u_pump_b (
    .clk         (clk),
    .rst         (rst),
    .start       (pump_start),
    .run         (pump_run),
    .enable      (cur_pb_en_q),
    .reverse     (1'b0),
    .pump_div    (pump_div),
    .phase_lines (pump_b)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_idx_q;
  assign ctrl_a   = ctrl_a_q;
  assign ctrl_s   = ctrl_s_q;

endmodule
